// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the program
// counter, keeps at most one instruction-memory request in flight, and buffers
// returned words together with their PCs in a small FIFO. The FIFO head is
// presented combinationally to IF/ID.
//
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   FIFO_DEPTH  fetch-buffer entries (power of 2, >= 2)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-low
//   stall        in   IF/ID not accepting; head entry is held
//   flush        in   redirect fetch to redirect_pc, clears the buffer
//   redirect_pc  in   new fetch address (low two bits ignored)
//   imem_req     out  request valid
//   imem_addr    out  request address (0 when no request)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   read data valid (no back-pressure)
//   imem_rdata   in   instruction word
//   if_pc        out  PC of head instruction, 0 when !if_valid
//   if_inst      out  head instruction, 0 when !if_valid
//   if_valid     out  head entry is presented to IF/ID
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      req_pc_reg, req_pc_next;
  logic             discard_reg, discard_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  logic has_space;
  logic handshake;
  logic outstanding;
  logic push;
  logic pop;

  // Redirect targets are forced to word alignment, so the low bits never matter.
  wire unused_ok = &{1'b0, redirect_pc[1:0]};

  // A request is only offered when the response is guaranteed a free slot,
  // which is why the FIFO can never overflow while waiting for data.
  assign has_space = (count_reg < DEPTH_C);
  assign imem_req  = (state_reg == REQ) && has_space;
  assign imem_addr = imem_req ? fetch_pc_reg : 32'h0;
  assign handshake = imem_req && imem_gnt;

  // A word is still owed by memory after this edge if a request is granted
  // now, or we are waiting and the data has not arrived this cycle.
  assign outstanding = handshake || ((state_reg == WAIT) && !imem_rvalid);

  assign push = (state_reg == WAIT) && imem_rvalid && !discard_reg && !flush;

  // Presentation is combinational from the head entry; a flush hides it in
  // the same cycle so IF/ID never latches a wrong-path instruction.
  assign if_valid = (count_reg != '0) && !flush;
  assign if_pc    = if_valid ? pc_mem[rd_ptr_reg]   : 32'h0;
  assign if_inst  = if_valid ? inst_mem[rd_ptr_reg] : 32'h0;
  assign pop      = if_valid && !stall;

  // ---------------------------------------------------------------------------
  // Fetch FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    discard_next  = discard_reg;

    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (handshake) begin
          req_pc_next = fetch_pc_reg;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // A discarded word belongs to a stale path, so the PC must not advance.
          if (discard_reg) begin
            discard_next = 1'b0;
          end else begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
          end
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides normal sequencing. If a word is still owed by memory
    // we must wait for it (and drop it) before the new path can be requested.
    if (flush) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      if (outstanding) begin
        discard_next = 1'b1;
        state_next   = WAIT;
      end else begin
        discard_next = 1'b0;
        state_next   = REQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= 32'h0;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      discard_reg  <= discard_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch buffer pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Buffer storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
      inst_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule
